matrix_mul_job_sched: RTL
=========================

// Module: matrix_mul_job_sched
// PURPOSE
//  Multi-requester job scheduler in front of matrix_mul_ctrl. Accepts matrix_mul_ctrl_t
//  job descriptors from NUM_REQ requesters through a round-robin arbiter and queues them
//  in a FIFO. Issues them one at a time on ctrl_info and reports each completion with
//  the requester id. Sits between the host/CSR job ports and matrix_mul_ctrl.
// PARAMETERS
//  NUM_REQ     4                    number of requester ports
//  FIFO_DEPTH  4                    queued descriptors, excluding the one in flight (power of 2)
//  ID_W        $clog2(NUM_REQ)      requester id width
// PORTS
//  clk          in   1                           clock
//  rst          in   1                           synchronous, active-high reset
//  req_valid    in   NUM_REQ                     per-requester descriptor valid
//  req_ready    out  NUM_REQ                     per-requester accept; push on valid&ready
//  req_desc     in   NUM_REQ x matrix_mul_ctrl_t job descriptor; .valid field ignored
//  ctrl_info    out  matrix_mul_ctrl_t           to matrix_mul_ctrl; .valid = job offer
//  ctrl_accept  in   1                           controller latched ctrl_info (1-cycle pulse)
//  ctrl_done    in   1                           controller finished last output write (pulse)
//  cpl_valid    out  1                           completion pulse, no backpressure
//  cpl_id       out  ID_W                        requester id of completed job
//  cpl_err      out  1                           job rejected (matrix_n == 0), never issued
//  busy         out  1                           state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FIFO empty; RR pointer 0; state IDLE.
//   - rst mid-job drops queued and in-flight jobs with no completion.
//   - matrix_mul_ctrl shares rst.
//  Arbiter:
//   - grant = first req_valid at or after pointer (cyclic).
//   - req_ready high only for the grantee, and only when FIFO not full.
//   - No bypass on a same-cycle pop: full => all ready low.
//   - Max one push per cycle. Pointer moves to grantee+1 on each push.
//  FIFO: entry {id, desc}; in-order; wrap-around on ptr overflow; full/empty from count.
//  FSM IDLE/ISSUE/RUN:
//   - IDLE & !empty & head.matrix_n==0:
//     - pop; next cycle cpl_valid=1, cpl_err=1, cpl_id=head.id; stay IDLE.
//   - IDLE & !empty & matrix_n!=0:
//     - pop; register desc into ctrl_info with .valid=1 -> ISSUE.
//   - ISSUE: ctrl_info held stable, .valid=1 until ctrl_accept. On accept: .valid=0 -> RUN.
//   - RUN: on ctrl_done, next cycle cpl_valid=1, cpl_err=0, cpl_id=job id -> IDLE.
//   - ctrl_done outside RUN is ignored. The controller guarantees done >= 1 cycle after accept.
//  Latency:
//   - Push at edge t into empty FIFO, FSM IDLE: ctrl_info.valid high from cycle t+2.
//   - ctrl_done at t: cpl_valid at t+1, new issue earliest t+2.
//  Completions:
//   - Emitted in issue order. cpl_valid is a single-cycle pulse.
//   - Consecutive error entries give back-to-back pulses.
// CONFIGURATION
//  MATRIX_MUL_SCHED_PERF_EN defined:
//   - Adds output cpl_cycles [31:0].
//   - Counter cleared on entry to ISSUE, increments every ISSUE/RUN cycle,
//     including the ctrl_done cycle.
//   - Value presented with cpl_valid; saturates at 32'hFFFF_FFFF.
//   - 0 on error completions; 0 out of reset.
//  Undefined: port and counter are absent; behaviour otherwise identical.
// STRUCTURE
//  matrix_mul_ctrl.svh additions:
//   - sched_entry_t {logic[ID_W-1:0] id; matrix_mul_ctrl_t desc;}
//   - sched_state_e {IDLE, ISSUE, RUN}
//  Sub-module: matrix_mul_sched_rr_arb (NUM_REQ-way round-robin grant + pointer).
//  FIFO and FSM are inline.
// TESTING
//  1 req0 pushes {a=8,b=8,c=64,n=8} at t:
//    -> ctrl_info.valid from t+2, fields equal, held until ctrl_accept;
//    -> ctrl_done -> cpl_valid, id=0, err=0 next cycle.
//  2 req0..3 valid together, pointer 0 -> pushes 0,1,2,3 on consecutive cycles;
//    completions ids 0,1,2,3 in order.
//  3 ctrl_accept held low, 6 jobs offered -> 5 accepted (1 in ctrl_info, 4 in FIFO);
//    6th req_ready low until first accept + pop.
//  4 jobs n=8, n=0, n=8 -> cpl ids in order; middle err=1; middle never on ctrl_info.valid.
//  5 rst during RUN -> next cycle outputs 0, busy=0, no cpl for dropped job;
//    fresh job after reset issued at t+2.
//  6 PERF_EN: valid high 3 cycles, ctrl_done on 10th RUN cycle -> cpl_cycles = 13.

Source files
------------

// File: rtl/matrix_mul_job_sched_pkg.sv
// Shared types for the matrix_mul job scheduler: the controller job descriptor,
// the queued FIFO entry, FSM state encoding and a saturating increment helper.
package matrix_mul_job_sched_pkg;

  localparam int SCHED_NUM_REQ    = 4;
  localparam int SCHED_FIFO_DEPTH = 4;
  localparam int SCHED_ID_W       = $clog2(SCHED_NUM_REQ);

  // Job descriptor understood by matrix_mul_ctrl; .valid marks a live offer.
  typedef struct packed {
    logic        valid;
    logic [15:0] a_addr;
    logic [15:0] b_addr;
    logic [15:0] c_addr;
    logic [7:0]  matrix_n;
  } matrix_mul_ctrl_t;

  typedef struct packed {
    logic [SCHED_ID_W-1:0] id;
    matrix_mul_ctrl_t      desc;
  } sched_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } sched_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/matrix_mul_job_sched_if.sv
// Requester, controller and completion signals of the job scheduler.
// MATRIX_MUL_SCHED_PERF_EN adds the cpl_cycles completion field.
interface matrix_mul_job_sched_if
  import matrix_mul_job_sched_pkg::*;
#(
  parameter int NUM_REQ = SCHED_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  matrix_mul_ctrl_t [NUM_REQ-1:0] req_desc;
  matrix_mul_ctrl_t               ctrl_info;
  logic                           ctrl_accept;
  logic                           ctrl_done;
  logic                           cpl_valid;
  logic [ID_W-1:0]                cpl_id;
  logic                           cpl_err;
  logic                           busy;
`ifdef MATRIX_MUL_SCHED_PERF_EN
  logic [31:0]                    cpl_cycles;
`endif

  // Environment side: requesters plus the downstream controller.
  modport master (
    output req_valid, req_desc, ctrl_accept, ctrl_done,
    input  req_ready, ctrl_info, cpl_valid, cpl_id, cpl_err, busy
`ifdef MATRIX_MUL_SCHED_PERF_EN
    , input cpl_cycles
`endif
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_desc, ctrl_accept, ctrl_done,
    output req_ready, ctrl_info, cpl_valid, cpl_id, cpl_err, busy
`ifdef MATRIX_MUL_SCHED_PERF_EN
    , output cpl_cycles
`endif
  );
endinterface

// File: rtl/matrix_mul_sched_rr_arb.sv
// NUM_REQ-way round-robin arbiter: grants the first valid requester at or after
// the pointer; the pointer moves past the grantee whenever a grant is consumed.
module matrix_mul_sched_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] ptr;

  // Cyclic search for the first active request starting at the pointer.
  always_comb begin
    // NOTE: every output is given a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req[(int'(ptr) + i) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign grant = grant_valid ? (NUM_REQ'(1) << grant_id) : '0;

  // Pointer advances to the slot after the grantee on each consumed grant.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_mul_job_sched.sv
// Job scheduler in front of matrix_mul_ctrl: round-robin intake from NUM_REQ
// requesters into an in-order FIFO, one job in flight at a time, one completion
// pulse per job (error pulse for matrix_n == 0 jobs, which are never issued).
// MATRIX_MUL_SCHED_PERF_EN adds a saturating ISSUE+RUN cycle count per completion.
module matrix_mul_job_sched
  import matrix_mul_job_sched_pkg::*;
#(
  parameter int NUM_REQ    = SCHED_NUM_REQ,
  parameter int FIFO_DEPTH = SCHED_FIFO_DEPTH,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input logic                   clk,
  input logic                   rst,
  matrix_mul_job_sched_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  sched_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  sched_entry_t       head;
  sched_entry_t       new_entry;

  sched_state_e       state;
  sched_state_e       state_nxt;
  logic               load;
  logic               accept_now;
  logic               err_cpl;
  logic               done_cpl;

  matrix_mul_ctrl_t   ctrl_info_q;
  matrix_mul_ctrl_t   issue_desc;
  logic [ID_W-1:0]    cur_id;
  logic               cpl_valid_q;
  logic [ID_W-1:0]    cpl_id_q;
  logic               cpl_err_q;

  // Intake: a requester is ready only while granted and the FIFO has room;
  // a same-cycle pop does not free a slot.
  assign full          = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign push          = grant_valid && !full && !rst;
  assign bus.req_ready = grant & {NUM_REQ{!full && !rst}};

  matrix_mul_sched_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req_valid),
    .advance     (push),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant       (grant)
  );

  assign head = mem[rd_ptr];

  // Entry captured from the granted requester.
  always_comb begin
    new_entry      = '0;
    new_entry.id   = SCHED_ID_W'(grant_id);
    new_entry.desc = bus.req_desc[grant_id];
  end

  // FIFO storage written on push.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only read after a push has written it.
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and single-cycle control strobes.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load       = 1'b0;
    accept_now = 1'b0;
    err_cpl    = 1'b0;
    done_cpl   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.desc.matrix_n == '0) begin
            err_cpl = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.ctrl_accept) begin
          accept_now = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (bus.ctrl_done) begin
          done_cpl  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Offered descriptor always carries valid=1 regardless of the requester's field.
  always_comb begin
    issue_desc       = head.desc;
    issue_desc.valid = 1'b1;
  end

  // Controller offer register and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_info_q <= '0;
      cur_id      <= '0;
      cpl_valid_q <= 1'b0;
      cpl_id_q    <= '0;
      cpl_err_q   <= 1'b0;
    end else begin
      cpl_valid_q <= err_cpl || done_cpl;
      cpl_err_q   <= err_cpl;
      cpl_id_q    <= err_cpl ? ID_W'(head.id) : (done_cpl ? cur_id : '0);
      if (load) begin
        ctrl_info_q <= issue_desc;
        cur_id      <= ID_W'(head.id);
      end else if (accept_now) begin
        ctrl_info_q.valid <= 1'b0;
      end
    end
  end

  assign bus.ctrl_info = ctrl_info_q;
  assign bus.cpl_valid = cpl_valid_q;
  assign bus.cpl_id    = cpl_id_q;
  assign bus.cpl_err   = cpl_err_q;
  assign bus.busy      = (state != IDLE) || !empty;

`ifdef MATRIX_MUL_SCHED_PERF_EN
  logic [31:0] run_cycles;
  logic [31:0] cpl_cycles_q;

  // Cycle count from ISSUE entry through the ctrl_done cycle, reported with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles   <= '0;
      cpl_cycles_q <= '0;
    end else begin
      cpl_cycles_q <= done_cpl ? sat_inc(run_cycles) : '0;
      if (load) begin
        run_cycles <= '0;
      end else if (state != IDLE) begin
        run_cycles <= sat_inc(run_cycles);
      end
    end
  end

  assign bus.cpl_cycles = cpl_cycles_q;
`endif

endmodule
